// File: rtl/mult_pkg.sv
// mult_pkg: shared state encoding, latency and register-file bit positions for the sequential multiplier
package mult_pkg;
  typedef enum logic [1:0] {IDLE, CALC, SIGN, DONE} mult_state_e;
  localparam int DATA_WIDTH = 32;
  localparam int MULT_LATENCY = DATA_WIDTH + 2;
  localparam int CTRL_START_BIT = 0;
  localparam int CTRL_SIGNED_BIT = 1;
  localparam int STAT_BUSY_BIT = 0;
  localparam int STAT_DONE_BIT = 1;
endpackage

// File: rtl/mult_shift_add_dp.sv
// mult_shift_add_dp: magnitude shift-add datapath with sign fix-up, sequenced by the core FSM
module mult_shift_add_dp #(
  parameter int W = 32,
  parameter int CW = $clog2(W) + 1
) (
  input  logic           clock,
  input  logic           reset,
  input  logic           load,
  input  logic           step,
  input  logic           fin,
  input  logic [W-1:0]   op_a,
  input  logic [W-1:0]   op_b,
  input  logic           signed_mode,
  output logic           last,
  output logic [2*W-1:0] product
);
  logic [2*W-1:0] acc, mcand;
  logic [W-1:0] mplier, a_mag, b_mag;
  logic [CW-1:0] cnt;
  logic neg;
  always_comb begin
    a_mag = (signed_mode & op_a[W-1]) ? -op_a : op_a;
    b_mag = (signed_mode & op_b[W-1]) ? -op_b : op_b;
    last = cnt == CW'(W - 1);
  end
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      acc <= '0;
      mcand <= '0;
      mplier <= '0;
      cnt <= '0;
      neg <= 1'b0;
      product <= '0;
    end else if (load) begin
      acc <= '0;
      mcand <= {{W{1'b0}}, a_mag};
      mplier <= b_mag;
      cnt <= '0;
      neg <= signed_mode & (op_a[W-1] ^ op_b[W-1]);
    end else if (step) begin
      acc <= mplier[0] ? acc + mcand : acc;
      mcand <= mcand << 1;
      mplier <= mplier >> 1;
      cnt <= cnt + 1'b1;
    end else if (fin) begin
      product <= neg ? -acc : acc;
    end
  end
endmodule

// File: rtl/mult_seq_core.sv
// mult_seq_core: radix-2 sequential multiplier with valid/ready operand and result handshakes
module mult_seq_core
  import mult_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int CNT_WIDTH = $clog2(DATA_WIDTH) + 1
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    start_valid,
  output logic                    start_ready,
  input  logic [DATA_WIDTH-1:0]   op_a,
  input  logic [DATA_WIDTH-1:0]   op_b,
  input  logic                    signed_mode,
  output logic                    result_valid,
  input  logic                    result_ready,
  output logic [2*DATA_WIDTH-1:0] product,
  output logic                    busy
);
  mult_state_e state, nxt;
  logic load, step, fin, last;
  always_ff @(posedge clock or posedge reset) begin
    if (reset) state <= IDLE;
    else state <= nxt;
  end
  always_comb begin
    nxt = state;
    nxt = state == IDLE ? (start_valid ? CALC : IDLE) :
          state == CALC ? (last ? SIGN : CALC) :
          state == SIGN ? DONE :
          (result_ready ? IDLE : DONE);
    start_ready = state == IDLE;
    result_valid = state == DONE;
    busy = state != IDLE;
    load = start_ready & start_valid;
    step = state == CALC;
    fin = state == SIGN;
  end
  mult_shift_add_dp #(.W(DATA_WIDTH), .CW(CNT_WIDTH)) u_dp (
    .clock(clock),
    .reset(reset),
    .load(load),
    .step(step),
    .fin(fin),
    .op_a(op_a),
    .op_b(op_b),
    .signed_mode(signed_mode),
    .last(last),
    .product(product)
  );
endmodule
